// File: rtl/capture_fifo_sync_if.sv
// Handshake/status bundle for capture_fifo_sync.
// The capture logic and reg_main connect through the master modport; the FIFO connects through the slave modport.
interface capture_fifo_sync_if #(
  parameter int pDATA_WIDTH = 18,
  parameter int pDEPTH      = 1024
);
  localparam int CW = $clog2(pDEPTH) + 1;

  logic                   I_wr;
  logic [pDATA_WIDTH-1:0] I_data;
  logic                   I_rd;
  logic [pDATA_WIDTH-1:0] O_data;
  logic                   I_flush;
  logic                   I_clear_errors;
  logic                   I_custom_flag;
  logic                   O_full;
  logic                   O_empty;
  logic                   O_prog_full;
  logic                   O_prog_empty;
  logic [CW-1:0]          O_count;
  logic                   O_overflow_sticky;
  logic                   O_underflow_sticky;
  logic                   O_error_flag;
  logic [5:0]             O_fifo_status;
  logic [CW-1:0]          O_high_water;

  modport master (
    output I_wr, I_data, I_rd, I_flush, I_clear_errors, I_custom_flag,
    input  O_data, O_full, O_empty, O_prog_full, O_prog_empty, O_count,
           O_overflow_sticky, O_underflow_sticky, O_error_flag,
           O_fifo_status, O_high_water
  );

  modport slave (
    input  I_wr, I_data, I_rd, I_flush, I_clear_errors, I_custom_flag,
    output O_data, O_full, O_empty, O_prog_full, O_prog_empty, O_count,
           O_overflow_sticky, O_underflow_sticky, O_error_flag,
           O_fifo_status, O_high_water
  );
endinterface

// File: rtl/capture_fifo_sync.sv
// Single-clock capture FIFO with a registered block-RAM read, occupancy flags, flush and sticky errors.
// Optional peak-occupancy monitor: define FIFO_HIGH_WATER_EN.
module capture_fifo_sync #(
  parameter int pDATA_WIDTH   = 18,
  parameter int pDEPTH        = 1024,
  parameter int pFULL_THRESH  = pDEPTH - 4,
  parameter int pEMPTY_THRESH = 4
) (
  input  logic                 cwusb_clk,
  input  logic                 reset_i,
  capture_fifo_sync_if.slave   fifo_if
);
  localparam int AW = $clog2(pDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(pDEPTH);
  localparam logic [CW-1:0] FULL_TH_C  = CW'(pFULL_THRESH);
  localparam logic [CW-1:0] EMPTY_TH_C = CW'(pEMPTY_THRESH);

  logic [pDATA_WIDTH-1:0] mem [pDEPTH];
  logic [pDATA_WIDTH-1:0] rd_data_q;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;
  logic                   full, empty, prog_empty;
  logic                   wr_en, rd_en;

  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign prog_empty = !empty && (count_q <= EMPTY_TH_C);

  // Acceptance uses the pre-edge flags; flush masks both sides entirely.
  assign wr_en = fifo_if.I_wr && !full  && !fifo_if.I_flush && !reset_i;
  assign rd_en = fifo_if.I_rd && !empty && !fifo_if.I_flush && !reset_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_if.I_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_en)      count_d = count_q + 1'b1;
      else if (rd_en && !wr_en) count_d = count_q - 1'b1;
    end
  end

  // A fresh error in the clear cycle keeps the flag set.
  always_comb begin
    ovf_d = (fifo_if.I_wr && full  && !fifo_if.I_flush) || (ovf_q && !fifo_if.I_clear_errors);
    udf_d = (fifo_if.I_rd && empty && !fifo_if.I_flush) || (udf_q && !fifo_if.I_clear_errors);
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge cwusb_clk) begin
    if (wr_en) mem[wr_ptr_q] <= fifo_if.I_data;
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i)    rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_ptr_q];
  end

`ifdef FIFO_HIGH_WATER_EN
  logic [CW-1:0] high_water_q, high_water_d;

  // Clearing restarts tracking from the occupancy that the edge will produce.
  always_comb begin
    high_water_d = high_water_q;
    if (fifo_if.I_clear_errors)      high_water_d = count_d;
    else if (count_d > high_water_q) high_water_d = count_d;
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) high_water_q <= '0;
    else         high_water_q <= high_water_d;
  end

  assign fifo_if.O_high_water = high_water_q;
`else
  assign fifo_if.O_high_water = '0;
`endif

  assign fifo_if.O_data             = rd_data_q;
  assign fifo_if.O_full             = full;
  assign fifo_if.O_empty            = empty;
  assign fifo_if.O_prog_full        = (count_q >= FULL_TH_C);
  assign fifo_if.O_prog_empty       = prog_empty;
  assign fifo_if.O_count            = count_q;
  assign fifo_if.O_overflow_sticky  = ovf_q;
  assign fifo_if.O_underflow_sticky = udf_q;
  assign fifo_if.O_error_flag       = ovf_q | udf_q;
  assign fifo_if.O_fifo_status      = {fifo_if.I_custom_flag, ovf_q, full, prog_empty, udf_q, empty};
endmodule

// File: tb/tb_capture_fifo_sync.sv
// Directed bench for capture_fifo_sync at depth 16, thresholds 12/2, 18-bit data.
// The high-water expectation follows whether FIFO_HIGH_WATER_EN is defined for the build.
module tb_capture_fifo_sync;
  localparam int W  = 18;
  localparam int D  = 16;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic srst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  capture_fifo_sync_if #(.pDATA_WIDTH(W), .pDEPTH(D)) fifo_if ();

  capture_fifo_sync #(
    .pDATA_WIDTH(W), .pDEPTH(D), .pFULL_THRESH(12), .pEMPTY_THRESH(2)
  ) dut (
    .cwusb_clk(clk),
    .reset_i  (srst),
    .fifo_if  (fifo_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input logic [W-1:0] d);
    fifo_if.I_wr = 1'b1;
    fifo_if.I_data = d;
    tick();
    fifo_if.I_wr = 1'b0;
  endtask

  task automatic rd_word();
    fifo_if.I_rd = 1'b1;
    tick();
    fifo_if.I_rd = 1'b0;
  endtask

  initial begin
    int hw_on;
    hw_on = 0;
`ifdef FIFO_HIGH_WATER_EN
    hw_on = 1;
`endif
    fifo_if.I_wr = 1'b0;
    fifo_if.I_rd = 1'b0;
    fifo_if.I_data = '0;
    fifo_if.I_flush = 1'b0;
    fifo_if.I_clear_errors = 1'b0;
    fifo_if.I_custom_flag = 1'b0;
    srst = 1'b1;
    tick();
    tick();
    srst = 1'b0;

    check("reset_count",  32'(fifo_if.O_count), 32'd0);
    check("reset_empty",  32'(fifo_if.O_empty), 32'd1);
    check("reset_full",   32'(fifo_if.O_full), 32'd0);
    check("reset_pfull",  32'(fifo_if.O_prog_full), 32'd0);
    check("reset_pempty", 32'(fifo_if.O_prog_empty), 32'd0);
    check("reset_data",   32'(fifo_if.O_data), 32'd0);
    check("reset_err",    32'(fifo_if.O_error_flag), 32'd0);
    check("reset_status", 32'(fifo_if.O_fifo_status), 32'h01);
    check("reset_hw",     32'(fifo_if.O_high_water), 32'd0);

    // Fill with 1..16
    for (int i = 1; i <= 16; i++) begin
      wr_word(W'(i));
      check($sformatf("fill_count_%0d", i),  32'(fifo_if.O_count), 32'(i));
      check($sformatf("fill_full_%0d", i),   32'(fifo_if.O_full), 32'(i == 16));
      check($sformatf("fill_pfull_%0d", i),  32'(fifo_if.O_prog_full), 32'(i >= 12));
      check($sformatf("fill_pempty_%0d", i), 32'(fifo_if.O_prog_empty), 32'(i <= 2));
    end

    // Overflow while full, custom flag raised
    fifo_if.I_custom_flag = 1'b1;
    wr_word(18'h3FFFF);
    check("ovf_sticky", 32'(fifo_if.O_overflow_sticky), 32'd1);
    check("ovf_err",    32'(fifo_if.O_error_flag), 32'd1);
    check("ovf_count",  32'(fifo_if.O_count), 32'd16);
    check("ovf_status", 32'(fifo_if.O_fifo_status), 32'h38);
    fifo_if.I_custom_flag = 1'b0;

    // Drain: 1..16 in order, no 0x3FFFF
    for (int i = 1; i <= 16; i++) begin
      rd_word();
      check($sformatf("drain_data_%0d", i),  32'(fifo_if.O_data), 32'(i));
      check($sformatf("drain_count_%0d", i), 32'(fifo_if.O_count), 32'(16 - i));
    end
    check("drain_empty", 32'(fifo_if.O_empty), 32'd1);
    tick();
    check("data_hold", 32'(fifo_if.O_data), 32'd16);

    // Underflow, clear, and same-cycle underflow+clear
    rd_word();
    check("udf_sticky", 32'(fifo_if.O_underflow_sticky), 32'd1);
    check("udf_data",   32'(fifo_if.O_data), 32'd16);
    fifo_if.I_clear_errors = 1'b1;
    tick();
    fifo_if.I_clear_errors = 1'b0;
    check("clr_udf", 32'(fifo_if.O_underflow_sticky), 32'd0);
    check("clr_ovf", 32'(fifo_if.O_overflow_sticky), 32'd0);
    check("clr_err", 32'(fifo_if.O_error_flag), 32'd0);
    fifo_if.I_clear_errors = 1'b1;
    rd_word();
    fifo_if.I_clear_errors = 1'b0;
    check("udf_clr_same", 32'(fifo_if.O_underflow_sticky), 32'd1);
    fifo_if.I_clear_errors = 1'b1;
    tick();
    fifo_if.I_clear_errors = 1'b0;

    // Simultaneous read/write at count 5
    for (int i = 1; i <= 5; i++) wr_word(W'(32'h100 + i));
    fifo_if.I_rd = 1'b1;
    wr_word(18'h00106);
    fifo_if.I_rd = 1'b0;
    check("sim5_count", 32'(fifo_if.O_count), 32'd5);
    check("sim5_data",  32'(fifo_if.O_data), 32'h101);
    for (int i = 2; i <= 6; i++) begin
      rd_word();
      check($sformatf("sim5_order_%0d", i), 32'(fifo_if.O_data), 32'h100 + 32'(i));
    end
    check("sim5_empty", 32'(fifo_if.O_empty), 32'd1);

    // Simultaneous read/write at count 0
    fifo_if.I_rd = 1'b1;
    wr_word(18'h00200);
    fifo_if.I_rd = 1'b0;
    check("sim0_count", 32'(fifo_if.O_count), 32'd1);
    check("sim0_udf",   32'(fifo_if.O_underflow_sticky), 32'd1);
    check("sim0_data",  32'(fifo_if.O_data), 32'h106);
    rd_word();
    check("sim0_read",  32'(fifo_if.O_data), 32'h200);

    // Flush at count 9 with a write pending; underflow flag still set
    for (int i = 1; i <= 9; i++) wr_word(W'(32'h2F0 + i));
    check("pre_flush_count", 32'(fifo_if.O_count), 32'd9);
    fifo_if.I_flush = 1'b1;
    wr_word(18'h2AAAA);
    fifo_if.I_flush = 1'b0;
    check("flush_count",  32'(fifo_if.O_count), 32'd0);
    check("flush_empty",  32'(fifo_if.O_empty), 32'd1);
    check("flush_pempty", 32'(fifo_if.O_prog_empty), 32'd0);
    check("flush_udf",    32'(fifo_if.O_underflow_sticky), 32'd1);
    check("flush_ovf",    32'(fifo_if.O_overflow_sticky), 32'd0);
    check("flush_data",   32'(fifo_if.O_data), 32'h200);
    wr_word(18'h00300);
    rd_word();
    check("post_flush_read", 32'(fifo_if.O_data), 32'h300);

    // High-water: write 10, read 7, write 2, then clear
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("hw_reset", 32'(fifo_if.O_high_water), 32'd0);
    for (int i = 1; i <= 10; i++) wr_word(W'(i));
    for (int i = 1; i <= 7; i++) rd_word();
    for (int i = 1; i <= 2; i++) wr_word(W'(i));
    check("hw_count", 32'(fifo_if.O_count), 32'd5);
    check("hw_peak",  32'(fifo_if.O_high_water), hw_on != 0 ? 32'd10 : 32'd0);
    fifo_if.I_clear_errors = 1'b1;
    tick();
    fifo_if.I_clear_errors = 1'b0;
    check("hw_clear", 32'(fifo_if.O_high_water), hw_on != 0 ? 32'd5 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
